// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM feeding a circular fetch queue.
// Optional FETCH_MISALIGN_TRAP_EN turns misaligned redirect targets into exception entries.
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] bp_pc,
  input  logic            bp_hit,
  input  logic            bp_taken,
  input  logic [XLEN-1:0] bp_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            fq_valid,
  input  logic            fq_ready,
  output logic [XLEN-1:0] fq_pc,
  output logic [31:0]     fq_instr,
  output logic            fq_pred_taken,
  output logic            fq_exc
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_e;
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, lpc_q, lpc_d;
  logic lpred_q, lpred_d, stall_q, stall_d;
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] cnt_q;
  logic [XLEN-1:0] pc_mem [FQ_DEPTH];
  logic [31:0] instr_mem [FQ_DEPTH];
  logic pred_mem [FQ_DEPTH];
  logic flush, misal, hs, pred, push, pop;
  logic [XLEN-1:0] raw_tgt, tgt, push_pc;
  assign flush   = trap_valid | redirect_valid;
  assign raw_tgt = trap_valid ? trap_pc : redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt   = raw_tgt;
  assign misal = |raw_tgt[1:0];
`else
  assign tgt   = raw_tgt & ~XLEN'(3);
  assign misal = 1'b0;
`endif
  assign pred           = bp_hit & bp_taken;
  assign bp_pc          = pc_q;
  assign imem_req_addr  = pc_q;
  assign imem_req_valid = rst && state_q == REQ && !stall_q && cnt_q < CW'(FQ_DEPTH);
  assign hs             = imem_req_valid & imem_req_ready;
  assign fq_valid       = cnt_q != '0;
  assign pop            = fq_valid & fq_ready & ~flush;
  // a flush may itself enqueue the misaligned-target exception entry
  assign push           = flush ? misal : (state_q == WAIT && imem_rsp_valid);
  assign push_pc        = flush ? tgt : lpc_q;
  assign fq_pc          = fq_valid ? pc_mem[head_q] : '0;
  assign fq_instr       = fq_valid ? instr_mem[head_q] : '0;
  assign fq_pred_taken  = fq_valid & pred_mem[head_q];
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lpc_d   = lpc_q;
    lpred_d = lpred_q;
    stall_d = stall_q;
    if (flush) begin
      pc_d    = tgt;
      stall_d = misal;
      // DROP only if a response is still owed after this edge
      state_d = (hs || (state_q != REQ && !imem_rsp_valid)) ? DROP : REQ;
    end else if (hs) begin
      state_d = WAIT;
      lpc_d   = pc_q;
      lpred_d = pred;
      pc_d    = pred ? bp_target : pc_q + XLEN'(4);
    end else if (state_q != REQ && imem_rsp_valid) begin
      state_d = REQ;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      lpc_q   <= '0;
      lpred_q <= 1'b0;
      stall_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lpc_q   <= lpc_d;
      lpred_q <= lpred_d;
      stall_q <= stall_d;
      tail_q  <= tail_q + AW'(push);
      head_q  <= flush ? tail_q : head_q + AW'(pop);
      cnt_q   <= flush ? CW'(push) : cnt_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]    <= push_pc;
      instr_mem[tail_q] <= flush ? '0 : imem_rsp_data;
      pred_mem[tail_q]  <= ~flush & lpred_q;
    end
  end
`ifdef FETCH_MISALIGN_TRAP_EN
  logic exc_mem [FQ_DEPTH];
  always_ff @(posedge clk) begin
    if (push) exc_mem[tail_q] <= flush;
  end
  assign fq_exc = fq_valid & exc_mem[head_q];
`else
  assign fq_exc = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a queue-based reference model.
module tb_fetch_unit;
  localparam int D = 4;
  logic clk = 0, rst = 0;
  logic trap_valid = 0, redirect_valid = 0, bp_hit = 0, bp_taken = 0;
  logic [63:0] trap_pc = 0, redirect_pc = 0, bp_target = 0, bp_pc, imem_req_addr, fq_pc;
  logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0, fq_valid, fq_ready = 0;
  logic fq_pred_taken, fq_exc;
  logic [31:0] imem_rsp_data = 0, fq_instr;
  always #5 clk = ~clk;
  fetch_unit #(.XLEN(64), .FQ_DEPTH(D), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_pc(trap_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .bp_pc(bp_pc),
    .bp_hit(bp_hit), .bp_taken(bp_taken), .bp_target(bp_target),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .fq_valid(fq_valid), .fq_ready(fq_ready),
    .fq_pc(fq_pc), .fq_instr(fq_instr), .fq_pred_taken(fq_pred_taken), .fq_exc(fq_exc)
  );
  typedef struct {logic [63:0] pc; logic [31:0] ins; logic pr; logic ex;} ent_t;
  ent_t q[$];
  logic [63:0] m_pc, p_pc;
  bit m_out, m_drop, m_stall, p_pred;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit exp_rv();
    return !m_out && !m_stall && q.size() < D;
  endfunction
  task automatic check_outs();
    bit rv = exp_rv();
    chk("req_valid", imem_req_valid, rv);
    chk("bp_pc", bp_pc, m_pc);
    if (rv) chk("req_addr", imem_req_addr, m_pc);
    chk("fq_valid", fq_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("fq_pc", fq_pc, q[0].pc);
      chk("fq_instr", fq_instr, q[0].ins);
      chk("fq_pred", fq_pred_taken, q[0].pr);
      chk("fq_exc", fq_exc, q[0].ex);
    end
  endtask
  task automatic step(bit tv, logic [63:0] tp, bit rv, logic [63:0] rp, bit hit, bit tk,
                      logic [63:0] tg, bit rdy, bit rsp, bit fqr);
    bit hs, fl;
    logic [63:0] t;
    @(negedge clk);
    trap_valid = tv; trap_pc = tp; redirect_valid = rv; redirect_pc = rp;
    bp_hit = hit; bp_taken = tk; bp_target = tg; imem_req_ready = rdy; fq_ready = fqr;
    imem_rsp_valid = rsp && m_out;
    imem_rsp_data = $urandom;
    #1 check_outs();
    hs = exp_rv() && rdy;
    fl = tv || rv;
    t = tv ? tp : rp;
    if (fl) begin
      q.delete();
      if (hs) begin m_out = 1; m_drop = 1; end
      else if (imem_rsp_valid) begin m_out = 0; m_drop = 0; end
      else if (m_out) m_drop = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc = t;
      m_stall = t[1:0] != 2'b00;
      if (m_stall) q.push_back('{t, 32'h0, 1'b0, 1'b1});
`else
      m_pc = {t[63:2], 2'b00};
`endif
    end else begin
      if (fqr && q.size() != 0) void'(q.pop_front());
      if (imem_rsp_valid) begin
        if (!m_drop) q.push_back('{p_pc, imem_rsp_data, p_pred, 1'b0});
        m_out = 0; m_drop = 0;
      end
      if (hs) begin
        m_out = 1; p_pc = m_pc; p_pred = hit && tk;
        m_pc = (hit && tk) ? tg : m_pc + 64'd4;
      end
    end
  endtask
  task automatic idle(bit rdy, bit rsp, bit fqr);
    step(0, 0, 0, 0, 0, 0, 0, rdy, rsp, fqr);
  endtask
  task automatic redir(logic [63:0] rp);
    step(0, 0, 1, rp, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 0; trap_valid = 0; redirect_valid = 0; imem_req_ready = 0; imem_rsp_valid = 0;
    fq_ready = 0; bp_hit = 0; bp_taken = 0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_fq_valid", fq_valid, 0);
    chk("rst_bp_pc", bp_pc, 0);
    chk("rst_fq_pc", fq_pc, 0);
    chk("rst_fq_instr", fq_instr, 0);
    chk("rst_fq_pred", fq_pred_taken, 0);
    chk("rst_fq_exc", fq_exc, 0);
    q.delete(); m_pc = 0; m_out = 0; m_drop = 0; m_stall = 0;
    @(negedge clk);
    rst = 1;
  endtask
  initial begin
    logic [63:0] t1, t2, t3;
    do_reset();
    for (int i = 0; i < 9; i++) idle(1, 1, 0);
    chk("full_no_req", imem_req_valid, 0);
    for (int i = 0; i < 4; i++) begin
      idle(0, 0, 1);
      chk("seq_pc", fq_pc, 64'(4 * i));
    end
    redir(64'h8);
    step(0, 0, 0, 0, 1, 1, 64'h100, 1, 0, 0);
    idle(0, 1, 0);
    chk("pred_addr", imem_req_addr, 64'h100);
    idle(0, 0, 0);
    chk("pred_entry_pc", fq_pc, 64'h8);
    chk("pred_entry_taken", fq_pred_taken, 1);
    idle(1, 0, 0);
    redir(64'h200);
    idle(1, 1, 0);
    chk("redir_flushed", fq_valid, 0);
    idle(1, 0, 0);
    idle(0, 1, 0);
    idle(0, 0, 0);
    chk("redir_entry_pc", fq_pc, 64'h200);
    step(1, 64'h80, 1, 64'h200, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0);
    chk("trap_prio", bp_pc, 64'h80);
    redir(64'h202);
    idle(0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misal_exc", fq_exc, 1);
    chk("misal_pc", fq_pc, 64'h202);
    chk("misal_no_req", imem_req_valid, 0);
`else
    chk("misal_forced", imem_req_addr, 64'h200);
`endif
    idle(1, 0, 0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      t1 = {$urandom, $urandom};
      t2 = {$urandom, $urandom};
      t3 = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(3) != 0) t1[1:0] = 2'b00;
      if ($urandom_range(3) != 0) t2[1:0] = 2'b00;
      step($urandom_range(49) == 0, t1, $urandom_range(24) == 0, t2, 1'($urandom),
           1'($urandom), t3, $urandom_range(9) < 7, 1'($urandom), 1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, 64, width of every PC and address field.
REQ-002 Parameter FQ_DEPTH, 4, fetch-queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, 0, PC loaded at reset.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 trap_valid  in  1  trap redirect request.
REQ-007 trap_pc  in  XLEN  trap target.
REQ-008 redirect_valid  in  1  mispredict redirect request from execute.
REQ-009 redirect_pc  in  XLEN  correct target.
REQ-010 bp_pc  out  XLEN  predictor lookup address; always equals the current PC.
REQ-011 bp_hit, bp_taken  in  1 each  predictor result for bp_pc, same cycle.
REQ-012 bp_target  in  XLEN  predicted target.
REQ-013 imem_req_valid  out  1; imem_req_addr  out  XLEN; imem_req_ready  in  1  request channel.
REQ-014 imem_rsp_valid  in  1; imem_rsp_data  in  32  response channel; one response per accepted request, in order.
REQ-015 fq_valid  out  1; fq_ready  in  1  decode handshake.
REQ-016 fq_pc  out  XLEN; fq_instr  out  32; fq_pred_taken  out  1; fq_exc  out  1  head-entry fields.

Function
REQ-017 The block SHALL keep at most one request outstanding, using FSM states REQ, WAIT and DROP.
REQ-018 In REQ, imem_req_valid SHALL be 1 only when (queue count + outstanding) < FQ_DEPTH; imem_req_addr SHALL equal the PC.
REQ-019 A request handshake (valid & ready) SHALL move the FSM to WAIT, latch the PC and the taken prediction (bp_hit & bp_taken), and update the PC to bp_target if predicted taken, else to PC+4 (modulo 2^XLEN).
REQ-020 In WAIT, imem_rsp_valid SHALL push {latched PC, imem_rsp_data, latched prediction, fq_exc=0} into the queue and return the FSM to REQ.
REQ-021 imem_rsp_valid SHALL be ignored in REQ.
REQ-022 Once asserted, imem_req_valid and imem_req_addr SHALL hold until handshake, except across a trap or redirect.
REQ-023 Priority SHALL be: reset > trap_valid > redirect_valid > prediction > sequential.
REQ-024 A trap or redirect in cycle N SHALL set the PC to its target and flush the queue to empty at edge N; a queue pop in cycle N SHALL be discarded.
REQ-025 Resulting state: from WAIT, or from REQ with a handshake in cycle N, go to DROP; otherwise stay in REQ. imem_req_addr SHALL show the new target at N+1.
REQ-026 In DROP, the next imem_rsp_valid SHALL be discarded and the FSM SHALL go to REQ; a further trap or redirect SHALL keep DROP.
REQ-027 The queue SHALL be circular with wrapping pointers; fq_valid = (count != 0); a pop SHALL occur on fq_valid & fq_ready.
REQ-028 On simultaneous push and pop, count SHALL be unchanged; the queue SHALL never overflow.
REQ-029 Latency: a response in cycle M SHALL appear at the queue head no earlier than M+1.

Reset
REQ-030 While rst=0: PC=RESET_PC, FSM=REQ, queue empty, imem_req_valid=0, fq_valid=0, all fq_* fields 0.
REQ-031 Reset asserted mid-transaction SHALL abandon the outstanding request; the first response after reset is not expected.

Configuration
REQ-032 With FETCH_MISALIGN_TRAP_EN defined: a trap or redirect target with bits [1:0] != 0 SHALL issue no request; instead it pushes a single entry {target, 32'h0, 0, fq_exc=1} and stalls in REQ until the next trap or redirect.
REQ-033 Without FETCH_MISALIGN_TRAP_EN: target bits [1:0] SHALL be forced to 0, and fq_exc SHALL be constant 0.

Verification
REQ-034 Reset release, imem_req_ready=1, 1-cycle responses, bp_hit=0 -> fq_pc = 0, 4, 8, 12 in order, with the instruction data matching.
REQ-035 bp_hit=bp_taken=1, bp_target=0x100 at PC 0x8 -> next imem_req_addr=0x100; entry for 0x8 has fq_pred_taken=1.
REQ-036 fq_ready=0, FQ_DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0 until a pop.
REQ-037 redirect_valid, redirect_pc=0x200 during WAIT -> queue empty next cycle; the pending response is dropped; next enqueued fq_pc=0x200.
REQ-038 trap_valid (trap_pc=0x80) and redirect_valid (0x200) in the same cycle -> PC=0x80; redirect_pc=0x202 -> fq_exc=1 entry if the macro is defined, else fetch at 0x200.
